// File: rtl/idex_pipe_stage.sv
// Elastic ID/EX stage: valid/ready handshake with a main register plus one skid entry,
// flush, halt latching. Optional perf counters under IDEX_PIPE_PERF_CNT_EN.
module idex_pipe_stage #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 24,
    parameter int REG_W  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    input  logic [REG_W-1:0]  in_dest,
    input  logic              in_halt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [REG_W-1:0]  out_dest,
    output logic              out_halt,
    output logic              halted
`ifdef IDEX_PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
`endif
);

    typedef struct packed {
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
        logic [REG_W-1:0]  dest;
        logic              halt;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t state_q, state_d;
    entry_t main_q, main_d, skid_q, skid_d, in_e;
    logic   halted_q, halted_d, rdy_q, rdy_d;
    logic   xfer_in, xfer_out, halt_out;

    assign in_e      = {in_ctrl, in_data, in_dest, in_halt};
    assign out_valid = (state_q != EMPTY);
    // rdy_q is already low while halted, so in_valid is ignored then
    assign xfer_in   = in_valid & rdy_q;
    assign xfer_out  = out_valid & out_ready;
    assign halt_out  = xfer_out & main_q.halt;

    always_comb begin
        state_d  = state_q;
        main_d   = main_q;
        skid_d   = skid_q;
        halted_d = halted_q | halt_out;
        case (state_q)
            EMPTY: begin
                if (xfer_in) begin
                    main_d  = in_e;
                    state_d = FULL;
                end
            end
            FULL: begin
                case ({xfer_out, xfer_in})
                    2'b11: main_d = in_e;
                    2'b10: state_d = EMPTY;
                    2'b01: begin
                        skid_d  = in_e;
                        state_d = SKID;
                    end
                    default: ;
                endcase
            end
            SKID: begin
                if (xfer_out) begin
                    main_d  = skid_q;
                    state_d = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Redirect or consumed HALT: drop everything queued, keep last payload visible
        if (flush || halt_out) begin
            state_d = EMPTY;
            main_d  = main_q;
            skid_d  = skid_q;
        end
        rdy_d = !halted_d && (state_d != SKID);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            main_q   <= '0;
            skid_q   <= '0;
            halted_q <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            main_q   <= main_d;
            skid_q   <= skid_d;
            halted_q <= halted_d;
            rdy_q    <= rdy_d;
        end
    end

    assign in_ready = rdy_q;
    assign halted   = halted_q;
    assign out_ctrl = out_valid ? main_q.ctrl : '0;
    assign out_data = main_q.data;
    assign out_dest = main_q.dest;
    assign out_halt = out_valid & main_q.halt;

`ifdef IDEX_PIPE_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_ONE;
            if (!out_valid && !halted_q && (bubble_cnt != '1))
                bubble_cnt <= bubble_cnt + CNT_ONE;
        end
    end
`else
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("CNT_W must be positive");
    end
`endif

endmodule

// File: tb/tb_idex_pipe_stage.sv
// Bench for idex_pipe_stage: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based model of the stage.
module tb_idex_pipe_stage;

    localparam int DW = 64;
    localparam int CW = 24;
    localparam int RW = 4;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, in_halt;
    logic [CW-1:0] in_ctrl, out_ctrl;
    logic [DW-1:0] in_data, out_data;
    logic [RW-1:0] in_dest, out_dest;
    logic          out_valid, out_ready, out_halt, halted;
`ifdef IDEX_PIPE_PERF_CNT_EN
    logic [NW-1:0] stall_cnt, bubble_cnt;
`endif

    idex_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .REG_W(RW), .CNT_W(NW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_ctrl(in_ctrl), .in_data(in_data), .in_dest(in_dest), .in_halt(in_halt),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ctrl(out_ctrl), .out_data(out_data), .out_dest(out_dest), .out_halt(out_halt),
        .halted(halted)
`ifdef IDEX_PIPE_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] ctrl;
        logic [DW-1:0] data;
        logic [RW-1:0] dest;
        logic          halt;
    } ent_t;

    // Model: instructions held by the stage, oldest first
    ent_t          q[$];
    ent_t          m_last = '0;
    bit            m_halted = 0;
    bit            m_rdy = 1;
    logic [NW-1:0] m_stall = '0, m_bub = '0;
    bit            chk_en = 0;
    int            n_cmp = 0, n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit tout, tin, hh;
        ent_t e;
        if (!rst_n) begin
            q.delete();
            m_last   = '0;
            m_halted = 0;
            m_rdy    = 1;
            m_stall  = '0;
            m_bub    = '0;
        end else begin
            if (q.size() > 0 && !out_ready && m_stall != '1) m_stall++;
            if (q.size() == 0 && !m_halted && m_bub != '1) m_bub++;
            tout = (q.size() > 0) && out_ready;
            tin  = in_valid && m_rdy;
            hh   = tout && q[0].halt;
            e    = {in_ctrl, in_data, in_dest, in_halt};
            if (tout) void'(q.pop_front());
            if (hh) m_halted = 1;
            if (flush || hh) q.delete();
            else if (tin) q.push_back(e);
            if (q.size() > 0) m_last = q[0];
            m_rdy = !m_halted && (q.size() < 2);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
            chk("out_ctrl", 64'(out_ctrl), (q.size() > 0) ? 64'(m_last.ctrl) : 64'd0);
            chk("out_data", out_data, m_last.data);
            chk("out_dest", 64'(out_dest), 64'(m_last.dest));
            chk("out_halt", {63'd0, out_halt}, {63'd0, (q.size() > 0) && m_last.halt});
            chk("in_ready", {63'd0, in_ready}, {63'd0, m_rdy});
            chk("halted", {63'd0, halted}, {63'd0, m_halted});
`ifdef IDEX_PIPE_PERF_CNT_EN
            chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
            chk("bubble_cnt", 64'(bubble_cnt), 64'(m_bub));
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [63:0] d, input logic h);
        in_valid = v;
        in_data  = d;
        in_ctrl  = d[CW-1:0] ^ 24'h5A5A5A;
        in_dest  = d[RW-1:0] ^ 4'h9;
        in_halt  = h;
    endtask

    initial begin
        rst_n = 0; flush = 0; out_ready = 0;
        put(1, 64'hAAAA, 0);
        repeat (3) tick();
        chk_en = 1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ctrl", 64'(out_ctrl), 64'd0);
        chk("rst_data", out_data, 64'd0);
        chk("rst_ready", {63'd0, in_ready}, 64'd1);

        rst_n = 1;
        tick();
        chk("first_cap", out_data, 64'hAAAA);

        // streaming at full rate
        out_ready = 1;
        for (int k = 1; k <= 4; k++) begin
            put(1, 64'(k), 0);
            tick();
            chk("stream_data", out_data, 64'(k));
            chk("stream_rdy", {63'd0, in_ready}, 64'd1);
        end
        put(0, 64'h0, 0);
        tick();
        chk("idle_valid", {63'd0, out_valid}, 64'd0);
        chk("idle_hold", out_data, 64'h4);

        // back-pressure fills the skid entry
        out_ready = 0;
        put(1, 64'h1111, 0); tick();
        put(1, 64'h2222, 0); tick();
        chk("bp_hold_a", out_data, 64'h1111);
        chk("bp_rdy_low", {63'd0, in_ready}, 64'd0);
        put(0, 64'h0, 0); out_ready = 1; tick();
        chk("bp_b", out_data, 64'h2222);
        tick();
        chk("bp_drained", {63'd0, out_valid}, 64'd0);

        // flush while two entries held, input in flush cycle dropped
        out_ready = 0;
        put(1, 64'h5555, 0); tick();
        put(1, 64'h6666, 0); tick();
        put(1, 64'h3333, 0); flush = 1; tick();
        flush = 0;
        chk("fl_valid", {63'd0, out_valid}, 64'd0);
        chk("fl_ctrl", 64'(out_ctrl), 64'd0);
        chk("fl_rdy", {63'd0, in_ready}, 64'd1);
        put(0, 64'h0, 0); out_ready = 1; tick();
        chk("fl_c_gone", {63'd0, out_valid}, 64'd0);

        // HALT consumed, follower discarded
        put(1, 64'h7777, 1); tick();
        chk("h_out_halt", {63'd0, out_halt}, 64'd1);
        put(1, 64'h4444, 0); tick();
        chk("h_halted", {63'd0, halted}, 64'd1);
        chk("h_rdy", {63'd0, in_ready}, 64'd0);
        chk("h_data_hold", out_data, 64'h7777);
        repeat (2) tick();
        chk("h_d_gone", {63'd0, out_valid}, 64'd0);
        flush = 1; tick(); flush = 0;
        chk("h_flush_sticky", {63'd0, halted}, 64'd1);

`ifdef IDEX_PIPE_PERF_CNT_EN
        rst_n = 0; put(0, 64'h0, 0); out_ready = 0; tick();
        rst_n = 1;
        repeat (3) tick();
        chk("p_bubble3", 64'(bubble_cnt), 64'd3);
        put(1, 64'hBEEF, 0); tick();
        put(0, 64'h0, 0);
        repeat (5) tick();
        chk("p_stall5", 64'(stall_cnt), 64'd5);
        repeat (12) tick();
        chk("p_stall_sat", 64'(stall_cnt), 64'hF);
        chk("p_bubble4", 64'(bubble_cnt), 64'd4);
`endif

        // random traffic
        rst_n = 0; tick();
        for (int i = 0; i < 3000; i++) begin
            rst_n     = m_halted ? ($urandom_range(7) != 0) : ($urandom_range(199) != 0);
            flush     = ($urandom_range(24) == 0);
            out_ready = ($urandom_range(9) < 6);
            put($urandom_range(9) < 7, {$urandom, $urandom}, $urandom_range(39) == 0);
            tick();
        end
        put(0, 64'h0, 0); flush = 0; rst_n = 1;
        tick();
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
